// File: rtl/bumper_hit_controller_pkg.sv
// rtl/bumper_hit_controller_pkg.sv - shared pinball types, widths and hit-side classifier
package bumper_hit_controller_pkg;

  localparam int PIXEL_W     = 11;
  localparam int CMP_W       = PIXEL_W + 1;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    SIDE_TOP    = 2'd0,
    SIDE_BOTTOM = 2'd1,
    SIDE_LEFT   = 2'd2,
    SIDE_RIGHT  = 2'd3
  } hit_side_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLASH    = 2'd1,
    ST_COOLDOWN = 2'd2
  } hit_state_t;

  // Top/bottom bands win over the left/right split at the bumper's centre line.
  function automatic hit_side_t classify_side(
    input logic signed [CMP_W-1:0] x,
    input logic signed [CMP_W-1:0] y,
    input logic signed [CMP_W-1:0] y_top,
    input logic signed [CMP_W-1:0] y_bot,
    input logic signed [CMP_W-1:0] x_mid
  );
    if (y < y_top)
      return SIDE_TOP;
    else if (y >= y_bot)
      return SIDE_BOTTOM;
    else if (x < x_mid)
      return SIDE_LEFT;
    else
      return SIDE_RIGHT;
  endfunction

endpackage

// File: rtl/bumper_hit_controller_frame_down_counter.sv
// rtl/bumper_hit_controller_frame_down_counter.sv - frame-rate down counter with load and zero flag
module frame_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load has priority; the count parks at zero rather than wrapping.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (tick && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bumper_hit_controller.sv
// rtl/bumper_hit_controller.sv - per-frame ball/bumper hit detection, flash and cooldown
module bumper_hit_controller
  import bumper_hit_controller_pkg::*;
#(
  parameter int TOP_LEFT_X      = 550,
  parameter int TOP_LEFT_Y      = 60,
  parameter int OBJECT_WIDTH    = 64,
  parameter int OBJECT_HEIGHT   = 32,
  parameter int EDGE            = 4,
  parameter int FLASH_FRAMES    = 8,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic signed [PIXEL_W-1:0] pixelX,
  input  logic signed [PIXEL_W-1:0] pixelY,
  input  logic                      drawBall,
  input  logic                      drawBumper,
  output logic                      hitPulse,
  output logic [1:0]                hitSide,
  output logic                      bumperLit,
  output logic [15:0]               hitCount
);

  localparam logic signed [CMP_W-1:0] Y_TOP = CMP_W'(TOP_LEFT_Y + EDGE);
  localparam logic signed [CMP_W-1:0] Y_BOT = CMP_W'(TOP_LEFT_Y + OBJECT_HEIGHT - EDGE);
  localparam logic signed [CMP_W-1:0] X_MID = CMP_W'(TOP_LEFT_X + OBJECT_WIDTH / 2);
  localparam logic [FRAME_CNT_W-1:0] FLASH_LOAD = FRAME_CNT_W'(FLASH_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] COOL_LOAD  =
    FRAME_CNT_W'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);

  logic                     overlap;
  logic signed [CMP_W-1:0]  x_ext;
  logic signed [CMP_W-1:0]  y_ext;
  hit_side_t                side_now;
  logic                     coll_flag;
  hit_side_t                side_latch;
  hit_state_t               state;
  hit_state_t               state_next;
  logic                     accept;
  logic                     cnt_load;
  logic [FRAME_CNT_W-1:0]   cnt_load_value;
  logic [FRAME_CNT_W-1:0]   cnt_value;
  logic                     cnt_zero;

  assign overlap  = drawBall & drawBumper;
  assign x_ext    = {pixelX[PIXEL_W-1], pixelX};
  assign y_ext    = {pixelY[PIXEL_W-1], pixelY};
  assign side_now = classify_side(x_ext, y_ext, Y_TOP, Y_BOT, X_MID);

  // On a frame boundary the old frame is judged from coll_flag while the
  // boundary pixel itself becomes the first pixel of the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coll_flag  <= 1'b0;
      side_latch <= SIDE_TOP;
    end else if (startOfFrame) begin
      coll_flag  <= overlap;
      side_latch <= overlap ? side_now : SIDE_TOP;
    end else if (overlap) begin
      coll_flag <= 1'b1;
      if (!coll_flag)
        side_latch <= side_now;
    end
  end

  frame_down_counter #(.WIDTH(FRAME_CNT_W)) u_frame_cnt (
    .clk        (clk),
    .resetN     (resetN),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .tick       (startOfFrame),
    .count      (cnt_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = FLASH_LOAD;
    case (state)
      ST_IDLE: begin
        if (startOfFrame && coll_flag) begin
          accept     = 1'b1;
          cnt_load   = 1'b1;
          state_next = ST_FLASH;
        end
      end
      ST_FLASH: begin
        if (startOfFrame && cnt_zero) begin
          if (COOLDOWN_FRAMES == 0) begin
            state_next = ST_IDLE;
          end else begin
            cnt_load       = 1'b1;
            cnt_load_value = COOL_LOAD;
            state_next     = ST_COOLDOWN;
          end
        end
      end
      ST_COOLDOWN: begin
        if (startOfFrame && cnt_zero)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bumperLit = (state == ST_FLASH);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitPulse <= 1'b0;
      hitSide  <= 2'd0;
      hitCount <= 16'd0;
    end else begin
      hitPulse <= accept;
      if (accept) begin
        hitSide <= side_latch;
        if (hitCount != 16'hFFFF)
          hitCount <= hitCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bumper_hit_controller.sv
// tb/tb_bumper_hit_controller.sv - directed and randomized checks of bumper_hit_controller
module tb_bumper_hit_controller;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic signed [10:0] pixelX;
  logic signed [10:0] pixelY;
  logic               drawBall;
  logic               drawBumper;
  logic               hitPulse;
  logic [1:0]         hitSide;
  logic               bumperLit;
  logic [15:0]        hitCount;

  int checks = 0;
  int errors = 0;

  // Frame-indexed model: boundaries are numbered; a hit at boundary b lights
  // the bumper until boundary b+8 and blocks judgement until boundary b+13.
  int m_frame, m_next_ok, m_lit_end, m_side;
  bit m_coll;
  bit e_pulse, e_lit;
  int e_side, e_count;

  always #5 clk = ~clk;

  bumper_hit_controller dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .drawBall     (drawBall),
    .drawBumper   (drawBumper),
    .hitPulse     (hitPulse),
    .hitSide      (hitSide),
    .bumperLit    (bumperLit),
    .hitCount     (hitCount)
  );

  function automatic int classify(input int x, input int y);
    if (y < 60 + 4)       return 0;
    if (y >= 60 + 32 - 4) return 1;
    if (x < 550 + 64 / 2) return 2;
    return 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_frame = 0; m_next_ok = 0; m_lit_end = -1; m_side = 0; m_coll = 0;
    e_pulse = 0; e_lit = 0; e_side = 0; e_count = 0;
  endtask

  task automatic model_edge(input bit sof, input bit ov, input int x, input int y);
    e_pulse = 0;
    if (sof) begin
      m_frame++;
      if (m_frame == m_lit_end) e_lit = 0;
      if (m_coll && m_frame >= m_next_ok) begin
        e_pulse = 1;
        e_side = m_side;
        if (e_count < 65535) e_count++;
        e_lit = 1;
        m_lit_end = m_frame + 8;
        m_next_ok = m_frame + 8 + 4 + 1;
      end
      m_coll = ov;
      m_side = ov ? classify(x, y) : 0;
    end else if (ov) begin
      if (!m_coll) m_side = classify(x, y);
      m_coll = 1;
    end
  endtask

  task automatic tick(input bit sof, input bit ov, input int x, input int y);
    startOfFrame = sof;
    pixelX = 11'(x);
    pixelY = 11'(y);
    if (ov) begin
      drawBall = 1'b1; drawBumper = 1'b1;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin drawBall = 1'b1; drawBumper = 1'b0; end
        1:       begin drawBall = 1'b0; drawBumper = 1'b1; end
        default: begin drawBall = 1'b0; drawBumper = 1'b0; end
      endcase
    end
    @(posedge clk);
    model_edge(sof, ov, x, y);
    @(negedge clk);
    chk("hitPulse", 32'(hitPulse), 32'(e_pulse));
    chk("hitSide", 32'(hitSide), 32'(e_side));
    chk("bumperLit", 32'(bumperLit), 32'(e_lit));
    chk("hitCount", 32'(hitCount), 32'(e_count));
  endtask

  task automatic quiet(input int n);
    repeat (n) tick(0, 0, $urandom_range(0, 800) - 100, $urandom_range(0, 600) - 100);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      tick(1, 0, 0, 0);
      quiet(3);
    end
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
    drawBall = 1'b0; drawBumper = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_pulse", 32'(hitPulse), 32'd0);
    chk("reset_side", 32'(hitSide), 32'd0);
    chk("reset_lit", 32'(bumperLit), 32'd0);
    chk("reset_count", 32'(hitCount), 32'd0);
    resetN = 1'b1;

    // Top hit, then the full flash/cooldown window.
    tick(1, 0, 0, 0); quiet(2); tick(0, 1, 580, 61); quiet(2);
    tick(1, 0, 0, 0);
    chk("t1_pulse", 32'(hitPulse), 32'd1);
    chk("t1_side", 32'(hitSide), 32'd0);
    chk("t1_count", 32'(hitCount), 32'd1);
    frames(14);

    // First overlapping pixel decides the side.
    quiet(2); tick(0, 1, 552, 75); quiet(1); tick(0, 1, 600, 75); quiet(1);
    tick(1, 0, 0, 0);
    chk("t2_side", 32'(hitSide), 32'd2);
    chk("t2_count", 32'(hitCount), 32'd2);
    frames(14);

    // Continuous contact scores once.
    repeat (3) begin
      quiet(1); tick(0, 1, 600, 90); quiet(1); tick(1, 0, 0, 0);
    end
    chk("t3_side", 32'(hitSide), 32'd1);
    chk("t3_count", 32'(hitCount), 32'd3);
    frames(13);
    quiet(1); tick(0, 1, 600, 75); quiet(1); tick(1, 0, 0, 0);
    chk("t3_right_pulse", 32'(hitPulse), 32'd1);
    chk("t3_right_side", 32'(hitSide), 32'd3);
    frames(14);

    // Overlap on the boundary cycle belongs to the new frame.
    tick(1, 1, 560, 75);
    chk("t4_no_early_pulse", 32'(hitPulse), 32'd0);
    quiet(2); tick(1, 0, 0, 0);
    chk("t4_pulse", 32'(hitPulse), 32'd1);
    chk("t4_side", 32'(hitSide), 32'd2);
    chk("t4_count", 32'(hitCount), 32'd5);

    // Asynchronous reset in the middle of the flash.
    frames(3);
    chk("t5_lit_before", 32'(bumperLit), 32'd1);
    resetN = 1'b0;
    #1;
    chk("t5_rst_lit", 32'(bumperLit), 32'd0);
    chk("t5_rst_count", 32'(hitCount), 32'd0);
    chk("t5_rst_pulse", 32'(hitPulse), 32'd0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    quiet(1); tick(0, 1, 600, 90); quiet(1); tick(1, 0, 0, 0);
    chk("t5_after_pulse", 32'(hitPulse), 32'd1);
    chk("t5_after_count", 32'(hitCount), 32'd1);
    frames(14);

    // Saturation from a preloaded count.
    force dut.hitCount = 16'hFFFE;
    #1;
    release dut.hitCount;
    e_count = 65534;
    quiet(1); tick(0, 1, 580, 61); tick(1, 0, 0, 0);
    chk("t6_reach_max", 32'(hitCount), 32'hFFFF);
    frames(14);
    quiet(1); tick(0, 1, 580, 61); tick(1, 0, 0, 0);
    chk("t6_sat_pulse", 32'(hitPulse), 32'd1);
    chk("t6_sat_count", 32'(hitCount), 32'hFFFF);
    frames(14);

    // Randomized frames of random length and overlap positions.
    repeat (300) begin
      tick(1, ($urandom_range(0, 7) == 0), $urandom_range(0, 800) - 100,
           $urandom_range(0, 600) - 100);
      repeat ($urandom_range(1, 10))
        tick(0, ($urandom_range(0, 7) == 0), $urandom_range(0, 800) - 100,
             $urandom_range(0, 600) - 100);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
